fp_mul_pipe: RTL and testbench
==============================

// Module: fp_mul_pipe
// PURPOSE
//   Pipelined IEEE-754 binary64/binary32 multiplier with valid/ready flow control, per-operation
//   precision select, all five IEEE rounding modes and a pass-through tag. It sits in the FPU
//   execute cluster beside the add/sub unit. Each operation is stamped with its own mode bits.
//   Up to STAGES operations are in flight, and results leave in issue order.
// PARAMETERS
//   STAGES  3  pipeline depth in registered stages (1..4); equals accept-to-result latency
//   TAG_W   4  width of in_tag/out_tag (>=1), carried unmodified with each operation
// PORTS
//   clk             in   1   clock, all state on rising edge
//   rst_n           in   1   asynchronous active-low reset
//   flush           in   1   synchronous kill of every in-flight operation
//   in_valid        in   1   operands/mode valid
//   in_ready        out  1   unit can accept this cycle
//   operand_a       in   64  SP operands use [31:0]; [63:32] are ignored
//   operand_b       in   64  same layout as operand_a
//   is_double_precision in 1 1=binary64, 0=binary32
//   rounding_mode   in   3   000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101..111 treated as RNE
//   in_tag          in   TAG_W  opaque id
//   out_valid       out  1   result valid
//   out_ready       in   1   consumer accepts result
//   result          out  64  SP result in [31:0], [63:32]=32'hFFFF_FFFF (NaN-boxed)
//   out_tag         out  TAG_W  tag of this result
//   flag_invalid/flag_overflow/flag_underflow/flag_inexact  out 1 each  IEEE flags for this result
// BEHAVIOUR
// - Reset: all stage valid bits=0; out_valid=0; result, out_tag, flags=0. in_ready=1 one cycle after release.
// - Transfer: in on in_valid&in_ready; out on out_valid&out_ready.
// - Pipeline: stage k advances when empty or stage k+1 advances.
//   in_ready = !v[0] | adv[0] is combinational from out_ready through the valid chain.
//   There is no extra bubble. With out_ready held at 1, one op per cycle, latency exactly STAGES.
// - Stall: out_valid=1 & out_ready=0 holds result/tag/flags stable until accepted.
// - flush: clears all valid bits next edge and wins over a same-cycle transfer. The same-cycle input is dropped.
// - Datapath: decode, then denormal normalise (leading-zero count), 53x53 multiply, 1-bit normalise.
//   Round uses lsb, guard and sticky over all discarded bits. A carry-out renormalises with exp+1.
//   The datapath is split across STAGES. The stage split is free, but results must be bit-identical for any STAGES.
// - Rounding, with s = result sign:
//   - RNE: up if g&(st|lsb)
//   - RTZ: never
//   - RDN: up if s&(g|st)
//   - RUP: up if !s&(g|st)
//   - RMM: up if g
// - Special values (checked in this order):
//   - any NaN -> canonical qNaN (DP 7FF8_0000_0000_0000, SP 7FC0_0000). Invalid iff any input is an sNaN.
//   - 0*Inf -> canonical qNaN, invalid
//   - either operand zero -> signed 0
//   - either operand Inf -> signed Inf
//   - no other flags in these cases.
// - Overflow (exp > emax after rounding): flag_overflow=flag_inexact=1.
//   - Result is Inf for RNE/RMM, RUP with s=0, and RDN with s=1.
//   - Otherwise the result is the max finite of sign s.
// - Underflow: tininess is detected before rounding (unbounded exp < emin).
//   - Mantissa is right-shifted with sticky collection, then rounded per mode. A round-up to min normal gives exp field 1.
//   - flag_underflow only if tiny AND inexact.
//   - Shift >= precision+1 gives 0 or min denormal per mode. The result is inexact.
// - flag_inexact = any discarded nonzero bit, or overflow.
// TESTING
//   DP 4000000000000000*4008000000000000, RNE -> 4018000000000000, no flags, out_valid exactly STAGES cycles after accept
//   SP 3FC00000*3FC00000 -> result FFFFFFFF40100000. SP 7F800000*00000000 -> FFFFFFFF7FC00000, invalid=1
//   DP 7FEFFFFFFFFFFFFF*4000000000000000: RNE -> 7FF0000000000000 OF+NX; RTZ -> 7FEFFFFFFFFFFFFF OF+NX
//   SP 00800001*3F000000: RNE -> 00400000 UF+NX; RUP -> 00400001 UF+NX. SP 00800000*3F000000 -> 00400000, no flags
//   STAGES=3, 8 back-to-back ops, out_ready=0 for cycles 4-8: in_ready drops, no loss/dup, tags 0..7 in order
//   Assert flush with 3 ops in flight plus a new in_valid: next cycle out_valid=0, no old result ever appears.
//   Assert rst_n low mid-stream: all outputs 0 immediately.

Source files
------------

// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754 binary64/binary32 multiplier with valid/ready flow control.
// The result is computed on the way into stage 0; the remaining stages form an elastic queue.
module fp_mul_pipe #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      operand_a,
  input  logic [63:0]      operand_b,
  input  logic             is_double_precision,
  input  logic [2:0]       rounding_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      result,
  output logic [TAG_W-1:0] out_tag,
  output logic             flag_invalid,
  output logic             flag_overflow,
  output logic             flag_underflow,
  output logic             flag_inexact
);

  localparam int unsigned EXP_W  = 13;
  localparam int unsigned SIG_W  = 53;
  localparam int unsigned PROD_W = 2 * SIG_W;

  typedef struct packed {
    logic [63:0]      res;
    logic [TAG_W-1:0] tag;
    logic             nv;
    logic             of;
    logic             uf;
    logic             nx;
  } op_t;

  typedef struct packed {
    logic        sign;
    logic [10:0] ef;
    logic [51:0] frac;
  } fields_t;

  typedef struct packed {
    logic [EXP_W-1:0] e;
    logic [SIG_W-1:0] sig;
  } norm_t;

  // SP fields are widened into the DP layout so one datapath serves both precisions.
  function automatic fields_t unpack(input logic [63:0] x, input logic dp);
    fields_t f;
    if (dp) f = {x[63], x[62:52], x[51:0]};
    else    f = {x[31], {3'b000, x[30:23]}, {x[22:0], 29'b0}};
    return f;
  endfunction

  function automatic logic [5:0] lzc53(input logic [SIG_W-1:0] x);
    logic [5:0] n;
    logic       hit;
    n   = '0;
    hit = 1'b0;
    for (int i = SIG_W - 1; i >= 0; i--) begin
      if (x[i]) hit = 1'b1;
      else if (!hit) n = n + 6'd1;
    end
    return n;
  endfunction

  // Unbiased exponent plus significand with its leading one at bit 52.
  function automatic norm_t normalise(input fields_t f, input logic [EXP_W-1:0] bias);
    norm_t            n;
    logic [SIG_W-1:0] raw;
    logic [5:0]       lz;
    raw   = {f.ef != 11'd0, f.frac};
    lz    = lzc53(raw);
    n.sig = raw << lz;
    n.e   = ((f.ef == 11'd0) ? 13'd1 : {2'b00, f.ef}) - bias - {7'b0, lz};
    return n;
  endfunction

  fields_t            fa, fb;
  norm_t              na, nb;
  logic               dp, sign, tiny, sticky_sh, g, st, up, carry, inexact, ovf, ovf_inf;
  logic               nan_a, nan_b, snan_any, inf_a, inf_b, zero_a, zero_b;
  logic [10:0]        exp_max;
  logic [EXP_W-1:0]   bias, emin, e_sum, e_n, sh_full, ef_fin;
  logic [PROD_W-1:0]  prod, norm, shifted;
  logic [6:0]         sh;
  logic [SIG_W-1:0]   kept;
  logic [SIG_W:0]     mant_r;
  logic [63:0]        fin_res, inf_res, max_res, zero_res, qnan_res;
  op_t                calc;

  always_comb begin
    dp       = is_double_precision;
    fa       = unpack(operand_a, dp);
    fb       = unpack(operand_b, dp);
    exp_max  = dp ? 11'h7FF : 11'h0FF;
    bias     = dp ? 13'd1023 : 13'd127;
    emin     = 13'd1 - bias;
    sign     = fa.sign ^ fb.sign;
    nan_a    = (fa.ef == exp_max) && (fa.frac != '0);
    nan_b    = (fb.ef == exp_max) && (fb.frac != '0);
    snan_any = (nan_a && !fa.frac[51]) || (nan_b && !fb.frac[51]);
    inf_a    = (fa.ef == exp_max) && (fa.frac == '0);
    inf_b    = (fb.ef == exp_max) && (fb.frac == '0);
    zero_a   = (fa.ef == 11'd0) && (fa.frac == '0);
    zero_b   = (fb.ef == 11'd0) && (fb.frac == '0);

    na    = normalise(fa, bias);
    nb    = normalise(fb, bias);
    prod  = {53'b0, na.sig} * {53'b0, nb.sig};
    e_sum = na.e + nb.e;
    if (prod[PROD_W-1]) begin
      norm = prod;
      e_n  = e_sum + 13'd1;
    end else begin
      norm = prod << 1;
      e_n  = e_sum;
    end

    // Tininess is judged before rounding; tiny values are denormalised with sticky.
    tiny      = $signed(e_n) < $signed(emin);
    sh_full   = emin - e_n;
    sh        = !tiny ? 7'd0 : (($signed(sh_full) > 13'sd107) ? 7'd107 : sh_full[6:0]);
    shifted   = norm >> sh;
    sticky_sh = (shifted << sh) != norm;

    if (dp) begin
      kept = shifted[105:53];
      g    = shifted[52];
      st   = (|shifted[51:0]) | sticky_sh;
    end else begin
      kept = {29'b0, shifted[105:82]};
      g    = shifted[81];
      st   = (|shifted[80:0]) | sticky_sh;
    end

    case (rounding_mode)
      3'b001:  begin up = 1'b0;             ovf_inf = 1'b0;  end
      3'b010:  begin up = sign & (g | st);  ovf_inf = sign;  end
      3'b011:  begin up = !sign & (g | st); ovf_inf = !sign; end
      3'b100:  begin up = g;                ovf_inf = 1'b1;  end
      default: begin up = g & (st | kept[0]); ovf_inf = 1'b1; end
    endcase

    mant_r  = {1'b0, kept} + {53'b0, up};
    carry   = dp ? mant_r[53] : mant_r[24];
    if (tiny) ef_fin = {12'b0, dp ? mant_r[52] : mant_r[23]};
    else      ef_fin = e_n + bias + {12'b0, carry};
    inexact = g | st;
    ovf     = !tiny && ($signed(ef_fin) >= $signed({2'b00, exp_max}));

    fin_res  = dp ? {sign, ef_fin[10:0], mant_r[51:0]}
                  : {32'hFFFF_FFFF, sign, ef_fin[7:0], mant_r[22:0]};
    inf_res  = dp ? {sign, 11'h7FF, 52'b0} : {32'hFFFF_FFFF, sign, 8'hFF, 23'b0};
    max_res  = dp ? {sign, 11'h7FE, {52{1'b1}}} : {32'hFFFF_FFFF, sign, 8'hFE, {23{1'b1}}};
    zero_res = dp ? {sign, 63'b0} : {32'hFFFF_FFFF, sign, 31'b0};
    qnan_res = dp ? 64'h7FF8_0000_0000_0000 : 64'hFFFF_FFFF_7FC0_0000;

    calc     = '0;
    calc.tag = in_tag;
    if (nan_a || nan_b) begin
      calc.res = qnan_res;
      calc.nv  = snan_any;
    end else if ((zero_a && inf_b) || (inf_a && zero_b)) begin
      calc.res = qnan_res;
      calc.nv  = 1'b1;
    end else if (zero_a || zero_b) begin
      calc.res = zero_res;
    end else if (inf_a || inf_b) begin
      calc.res = inf_res;
    end else if (ovf) begin
      calc.res = ovf_inf ? inf_res : max_res;
      calc.of  = 1'b1;
      calc.nx  = 1'b1;
    end else begin
      calc.res = fin_res;
      calc.nx  = inexact;
      calc.uf  = tiny & inexact;
    end
  end

  op_t               pipe_q [STAGES];
  op_t               src    [STAGES];
  logic [STAGES-1:0] v_q, adv, src_v;
  logic              ready_en_q;

  // A stage advances when it is empty or its successor advances.
  always_comb begin
    adv             = '0;
    adv[STAGES-1]   = !v_q[STAGES-1] | out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) adv[k] = !v_q[k] | adv[k+1];
    src_v    = '0;
    src_v[0] = in_valid;
    src[0]   = calc;
    for (int k = 1; k < int'(STAGES); k++) begin
      src_v[k] = v_q[k-1];
      src[k]   = pipe_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q        <= '0;
      ready_en_q <= 1'b0;
      for (int k = 0; k < int'(STAGES); k++) pipe_q[k] <= '0;
    end else begin
      ready_en_q <= 1'b1;
      for (int k = 0; k < int'(STAGES); k++) begin
        if (adv[k]) begin
          v_q[k] <= src_v[k];
          if (src_v[k]) pipe_q[k] <= src[k];
        end
      end
      if (flush) v_q <= '0;
    end
  end

  assign in_ready       = ready_en_q & adv[0];
  assign out_valid      = v_q[STAGES-1];
  assign result         = pipe_q[STAGES-1].res;
  assign out_tag        = pipe_q[STAGES-1].tag;
  assign flag_invalid   = pipe_q[STAGES-1].nv;
  assign flag_overflow  = pipe_q[STAGES-1].of;
  assign flag_underflow = pipe_q[STAGES-1].uf;
  assign flag_inexact   = pipe_q[STAGES-1].nx;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: directed IEEE cases, real-arithmetic DP checks,
// stall, flush and asynchronous reset behaviour.
module tb_fp_mul_pipe;
  localparam int unsigned STAGES = 3;
  localparam int unsigned TAG_W  = 4;
  localparam logic [2:0] RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100;
  localparam logic [3:0] F_NONE = 4'b0000, F_NV = 4'b1000, F_OFNX = 4'b0101, F_UFNX = 4'b0011,
                         F_NX = 4'b0001, M_ALL = 4'b1111, M_NONX = 4'b1110;

  typedef struct packed {
    logic [63:0]      res;
    logic [TAG_W-1:0] tag;
    logic [3:0]       flags;
    logic [3:0]       mask;
  } exp_t;

  logic             clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, in_ready;
  logic [63:0]      operand_a = '0, operand_b = '0, result;
  logic             is_double_precision = 1'b0;
  logic [2:0]       rounding_mode = 3'b000;
  logic [TAG_W-1:0] in_tag = '0, out_tag;
  logic             out_valid, out_ready = 1'b1;
  logic             flag_invalid, flag_overflow, flag_underflow, flag_inexact;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0, failures = 0, cyc = 0, next_tag = 0;
  bit   stall_en = 0, hold_off = 0, drop_mode = 0, saw_block = 0, accepted = 0;

  fp_mul_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(operand_a), .operand_b(operand_b), .is_double_precision(is_double_precision),
    .rounding_mode(rounding_mode), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag), .flag_invalid(flag_invalid), .flag_overflow(flag_overflow),
    .flag_underflow(flag_underflow), .flag_inexact(flag_inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("spurious_out_valid", {63'b0, out_valid}, 64'd0);
    end else begin
      e = sb.pop_front();
      chk("result", result, e.res);
      chk("out_tag", {60'b0, out_tag}, {60'b0, e.tag});
      chk("flags", {60'b0, {flag_invalid, flag_overflow, flag_underflow, flag_inexact} & e.mask},
          {60'b0, e.flags & e.mask});
    end
  endtask

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    if (in_valid && !in_ready) saw_block = 1'b1;
    accepted = in_valid && in_ready;
    if (out_valid && out_ready) check_out();
    if (accepted && !flush && !drop_mode) sb.push_back(cur);
    @(posedge clk);
    #1;
    cyc++;
    out_ready = !(hold_off || (stall_en && cyc >= 4 && cyc <= 8));
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic dp,
                      input logic [2:0] rm, input logic [63:0] res, input logic [3:0] flags,
                      input logic [3:0] mask);
    operand_a = a; operand_b = b; is_double_precision = dp; rounding_mode = rm;
    in_tag = TAG_W'(next_tag);
    cur = '{res, TAG_W'(next_tag), flags, mask};
    next_tag++;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int n = 0; n < 100 && !accepted; n++) tick();
    if (!accepted) chk("accept_timeout", {63'b0, accepted}, 64'd1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int n = 0; n < 200 && sb.size() != 0; n++) tick();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [63:0] rand_dp(input bit exact);
    logic [63:0] x;
    x[63]    = 1'($urandom_range(0, 1));
    x[62:52] = 11'($urandom_range(896, 1151));
    x[51:32] = 20'($urandom);
    x[31:0]  = $urandom;
    if (exact) x[28:0] = '0;
    return x;
  endfunction

  task automatic send_real(input bit exact);
    logic [63:0] a, b, r;
    a = rand_dp(exact);
    b = rand_dp(exact);
    r = $realtobits($bitstoreal(a) * $bitstoreal(b));
    send(a, b, 1'b1, RNE, r, F_NONE, exact ? M_ALL : M_NONX);
  endtask

  initial begin
    int n;
    #3;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_tag", {60'b0, out_tag}, 64'd0);
    chk("rst_flags", {60'b0, flag_invalid, flag_overflow, flag_underflow, flag_inexact}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("in_ready_at_release", {63'b0, in_ready}, 64'd0);
    @(posedge clk); #1;
    chk("in_ready_after_release", {63'b0, in_ready}, 64'd1);

    // First-result latency
    send(64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 1'b1, RNE,
         64'h4018_0000_0000_0000, F_NONE, M_ALL);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", 64'(n), 64'(STAGES));
    drain();

    // Directed special, overflow, underflow and rounding cases, issued back to back
    send(64'h1234_5678_3FC0_0000, 64'hDEAD_BEEF_3FC0_0000, 1'b0, RNE, 64'hFFFF_FFFF_4010_0000, F_NONE, M_ALL);
    send(64'h7F80_0000, 64'h0, 1'b0, RNE, 64'hFFFF_FFFF_7FC0_0000, F_NV, M_ALL);
    send(64'h7FEF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000, 1'b1, RNE, 64'h7FF0_0000_0000_0000, F_OFNX, M_ALL);
    send(64'h7FEF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000, 1'b1, RTZ, 64'h7FEF_FFFF_FFFF_FFFF, F_OFNX, M_ALL);
    send(64'h7FEF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000, 1'b1, RDN, 64'h7FEF_FFFF_FFFF_FFFF, F_OFNX, M_ALL);
    send(64'hFFEF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000, 1'b1, RDN, 64'hFFF0_0000_0000_0000, F_OFNX, M_ALL);
    send(64'hFFEF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000, 1'b1, RUP, 64'hFFEF_FFFF_FFFF_FFFF, F_OFNX, M_ALL);
    send(64'h7FEF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000, 1'b1, 3'b110, 64'h7FF0_0000_0000_0000, F_OFNX, M_ALL);
    send(64'h0080_0001, 64'h3F00_0000, 1'b0, RNE, 64'hFFFF_FFFF_0040_0000, F_UFNX, M_ALL);
    send(64'h0080_0001, 64'h3F00_0000, 1'b0, RUP, 64'hFFFF_FFFF_0040_0001, F_UFNX, M_ALL);
    send(64'h0080_0000, 64'h3F00_0000, 1'b0, RNE, 64'hFFFF_FFFF_0040_0000, F_NONE, M_ALL);
    send(64'h0000_0001, 64'h3F00_0000, 1'b0, RNE, 64'hFFFF_FFFF_0000_0000, F_UFNX, M_ALL);
    send(64'h0000_0001, 64'h3F00_0000, 1'b0, RMM, 64'hFFFF_FFFF_0000_0001, F_UFNX, M_ALL);
    send(64'h0000_0001, 64'h0000_0001, 1'b0, RUP, 64'hFFFF_FFFF_0000_0001, F_UFNX, M_ALL);
    send(64'h8000_0001, 64'h0000_0001, 1'b0, RDN, 64'hFFFF_FFFF_8000_0001, F_UFNX, M_ALL);
    send(64'h0000_0001, 64'h0000_0001, 1'b0, RDN, 64'hFFFF_FFFF_0000_0000, F_UFNX, M_ALL);
    send(64'h3F80_0001, 64'h3F80_0001, 1'b0, RNE, 64'hFFFF_FFFF_3F80_0002, F_NX, M_ALL);
    send(64'h3F80_0001, 64'h3F80_0001, 1'b0, RUP, 64'hFFFF_FFFF_3F80_0003, F_NX, M_ALL);
    send(64'h0000_0000_0000_0001, 64'h4330_0000_0000_0000, 1'b1, RNE, 64'h0010_0000_0000_0000, F_NONE, M_ALL);
    send(64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000, 1'b1, RNE, 64'h7FF8_0000_0000_0000, F_NV, M_ALL);
    send(64'hFFC0_0000, 64'h3F80_0000, 1'b0, RNE, 64'hFFFF_FFFF_7FC0_0000, F_NONE, M_ALL);
    send(64'h7F80_0001, 64'h0, 1'b0, RNE, 64'hFFFF_FFFF_7FC0_0000, F_NV, M_ALL);
    send(64'h0, 64'hC008_0000_0000_0000, 1'b1, RNE, 64'h8000_0000_0000_0000, F_NONE, M_ALL);
    send(64'h7F80_0000, 64'hC000_0000, 1'b0, RNE, 64'hFFFF_FFFF_FF80_0000, F_NONE, M_ALL);
    for (int i = 0; i < 12; i++) send_real(i[0]);
    drain();

    // Eight back-to-back ops with out_ready low for cycles 4..8
    next_tag = 0; cyc = 0; stall_en = 1; saw_block = 0;
    for (int i = 0; i < 8; i++) send_real(i[0]);
    drain();
    stall_en = 0;
    chk("in_ready_dropped", {63'b0, saw_block}, 64'd1);

    // Flush with three ops in flight plus a same-cycle input
    drop_mode = 1; hold_off = 1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_real(1'b1);
    flush = 1'b1;
    operand_a = 64'h4000_0000_0000_0000;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
    drop_mode = 0; hold_off = 0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    send(64'h3FC0_0000, 64'h4000_0000, 1'b0, RTZ, 64'hFFFF_FFFF_4040_0000, F_NONE, M_ALL);
    drain();

    // Asynchronous reset in the middle of a stream
    for (int i = 0; i < 4; i++) send_real(1'b1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("mid_rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("mid_rst_result", result, 64'd0);
    chk("mid_rst_tag", {60'b0, out_tag}, 64'd0);
    chk("mid_rst_flags", {60'b0, flag_invalid, flag_overflow, flag_underflow, flag_inexact}, 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_mid_rst", {63'b0, in_ready}, 64'd1);
    send(64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 1'b1, RNE,
         64'h4018_0000_0000_0000, F_NONE, M_ALL);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
